apb_master: RTL and testbench
=============================

// Module: apb_master
// PURPOSE
// - APB3 requester: turns a simple valid/ready command port into APB SETUP/ACCESS transfers.
// - Returns a one-cycle response pulse carrying read data and error status.
// - Drives the requester side of apb_if toward apb_slave. Also serves as an RTL bus driver for
//   the memory bench.
// PARAMETERS
// ADDR_W    32  paddr / cmd_addr width
// DATA_W    32  pwdata / prdata width
// TIMEOUT   16  max ACCESS cycles waiting for pready before abort; 0 = no timeout
// PORTS
// pclk         in   1       clock; all logic on rising edge
// presetn      in   1       reset, asynchronous, active-low
// cmd_valid    in   1       command request
// cmd_ready    out  1       command accepted when cmd_valid && cmd_ready
// cmd_write    in   1       1 = write, 0 = read
// cmd_addr     in   ADDR_W  transfer address
// cmd_wdata    in   DATA_W  write data (ignored for reads)
// rsp_valid    out  1       one-cycle completion pulse (no backpressure)
// rsp_rdata    out  DATA_W  read data; 0 for writes and aborts
// rsp_err      out  1       pslverr seen, or timeout
// rsp_timeout  out  1       transfer aborted by timeout
// psel         out  1       APB select
// penable      out  1       APB enable
// pwrite       out  1       APB direction
// paddr        out  ADDR_W  APB address
// pwdata       out  DATA_W  APB write data
// prdata       in   DATA_W  APB read data
// pready       in   1       APB ready; low inserts wait states
// pslverr      in   1       APB error; sampled only on completion
// BEHAVIOUR
// - Reset (presetn=0, async): state=IDLE.
//   - psel, penable, pwrite, paddr, pwdata, rsp_* are all 0.
//   - cmd_ready is 0 while presetn=0 and 1 from the first edge after release.
// - FSM: IDLE -> SETUP -> ACCESS -> IDLE. All APB outputs are registered.
//   - IDLE: cmd_ready=1, psel=0, penable=0. On accept, latch write/addr/wdata -> SETUP.
//   - SETUP (exactly 1 cycle): psel=1, penable=0, paddr/pwrite/pwdata = latched values -> ACCESS.
//   - ACCESS: psel=1, penable=1.
//     - paddr, pwrite and pwdata are held stable.
//     - Wait-state counter starts at 0 on entry and increments every cycle pready=0.
//   - Completion: at the edge where state=ACCESS and pready=1.
//     - Capture prdata for reads (0 for writes) and pslverr.
//     - rsp_valid=1 for one cycle; next state IDLE, so psel=0 and penable=0.
//   - Timeout (TIMEOUT>0): at the edge where the counter reaches TIMEOUT with pready still 0.
//     - Abort: rsp_valid=1, rsp_err=1, rsp_timeout=1, rsp_rdata=0.
//     - Next state IDLE.
// - Latency with pready=1: accept at edge 0, SETUP cycle 1, ACCESS cycle 2, rsp_valid cycle 3.
//   - cmd_ready is also 1 in cycle 3, so back-to-back commands give 1 transfer per 3 cycles.
// - Each wait state adds exactly 1 cycle.
// - rsp_* fields are valid only while rsp_valid=1 and return to 0 the cycle after.
// - Completion and pready arriving on the same cycle as the TIMEOUT limit: completion wins.
//   rsp_timeout=0.
// - pslverr is ignored while pready=0.
// - cmd_valid with cmd_ready=0: command is not accepted; the caller holds it.
// - presetn asserted mid-transfer: the transfer is dropped and APB outputs go to 0 immediately.
//   No rsp_valid is produced for the dropped transfer.
// STRUCTURE
// - apb_pkg holds:
//   - typedef enum logic [1:0] {APB_IDLE, APB_SETUP, APB_ACCESS} apb_state_e
//   - APB_ADDR_W / APB_DATA_W defaults
//   - typedef struct apb_rsp_t {rdata, err, timeout}
// - Sub-module apb_wait_timer: wait-state counter of width $clog2(TIMEOUT+1).
//   - Inputs clr, inc. Output expired. Tied to expired=0 when TIMEOUT=0.
// TESTING
// - Write addr 5, data 0xDEADBEEF, pready=1:
//   - psel=1/penable=0 cycle 1, penable=1 cycle 2.
//   - rsp_valid cycle 3, rsp_err=0; slave mem[5]=0xDEADBEEF.
// - Read addr 5 after reset against apb_slave: rsp_rdata=0x5, rsp_err=0.
//   - Then write 0xA5 to addr 7 and read it back: rsp_rdata=0xA5.
// - Read with pready held low 3 cycles in ACCESS:
//   - ACCESS lasts 4 cycles; paddr/pwrite stable throughout; rsp_valid in cycle 6.
// - TIMEOUT=8, pready stuck 0:
//   - rsp_valid after 8 ACCESS cycles, rsp_err=1, rsp_timeout=1, rsp_rdata=0.
//   - psel=0 the next cycle; cmd_ready=1.
// - pslverr=1 with pready=1 on a write: rsp_err=1, rsp_timeout=0.
//   - Next command accepted normally.
// - presetn pulled low during ACCESS: psel/penable/cmd_ready=0 without waiting for pclk.
//   - No rsp_valid. After release, a read of addr 3 returns 0x3.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared types and width defaults for the APB requester and its bus interface.
package apb_pkg;

    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;

    typedef enum logic [1:0] {
        APB_IDLE,
        APB_SETUP,
        APB_ACCESS
    } apb_state_e;

    // Completion payload returned alongside the one-cycle rsp_valid pulse.
    typedef struct packed {
        logic [APB_DATA_W-1:0] rdata;
        logic                  err;
        logic                  timeout;
    } apb_rsp_t;

endpackage

// File: rtl/apb_if.sv
// APB3 bus signals between one requester and one completer.
interface apb_if
    import apb_pkg::*;
#(
    parameter int ADDR_W = APB_ADDR_W,
    parameter int DATA_W = APB_DATA_W
);

    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );

endinterface

// File: rtl/apb_wait_timer.sv
// Counts ACCESS wait states and flags the cycle on which the wait limit is hit.
// expired is combinational so the FSM can abort on that same edge.
module apb_wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic pclk,
    input  logic presetn,
    input  logic clr,
    input  logic inc,
    output logic expired
);

    if (TIMEOUT == 0) begin : g_no_timeout
        assign expired = 1'b0;

        logic unused_inputs;
        assign unused_inputs = &{1'b0, pclk, presetn, clr, inc};
    end else begin : g_timeout
        localparam int              CNT_W = $clog2(TIMEOUT + 1);
        localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;

        // Next count: cleared outside ACCESS, bumped on every pready-low cycle.
        always_comb begin
            // NOTE: default every always_comb output first so no path can infer a latch.
            cnt_d = cnt_q;
            if (clr) begin
                cnt_d = '0;
            end else if (inc) begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        // Wait-state counter register.
        always_ff @(posedge pclk or negedge presetn) begin
            // NOTE: sequential state uses <= so every flop updates from pre-edge values.
            if (!presetn) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        // The increment that would take the count to TIMEOUT is the abort edge.
        assign expired = inc && (cnt_q == LAST);
    end

endmodule

// File: rtl/apb_master.sv
// APB3 requester: accepts valid/ready commands, runs SETUP/ACCESS on the bus and
// returns a single-cycle response with read data, slave error and timeout status.
module apb_master
    import apb_pkg::*;
#(
    parameter int ADDR_W  = APB_ADDR_W,
    parameter int DATA_W  = APB_DATA_W,
    parameter int TIMEOUT = 16
) (
    input  logic              pclk,
    input  logic              presetn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    apb_if.master             apb
);

    apb_state_e        state_q,     state_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              psel_q,      psel_d;
    logic              penable_q,   penable_d;
    logic              pwrite_q,    pwrite_d;
    logic [ADDR_W-1:0] paddr_q,     paddr_d;
    logic [DATA_W-1:0] pwdata_q,    pwdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    apb_rsp_t          rsp_q,       rsp_d;

    logic timer_clr;
    logic timer_inc;
    logic timer_expired;

    assign timer_clr = (state_q != APB_ACCESS);
    assign timer_inc = (state_q == APB_ACCESS) && !apb.pready;

    apb_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .pclk    (pclk),
        .presetn (presetn),
        .clr     (timer_clr),
        .inc     (timer_inc),
        .expired (timer_expired)
    );

    // FSM next state plus next values of every registered bus/response output.
    always_comb begin
        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = 1'b0;
        rsp_d       = '0;

        case (state_q)
            APB_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    state_d     = APB_SETUP;
                    cmd_ready_d = 1'b0;
                    psel_d      = 1'b1;
                    penable_d   = 1'b0;
                    pwrite_d    = cmd_write;
                    paddr_d     = cmd_addr;
                    pwdata_d    = cmd_wdata;
                end else begin
                    // Covers the first edge after reset release.
                    cmd_ready_d = 1'b1;
                end
            end

            APB_SETUP: begin
                state_d   = APB_ACCESS;
                penable_d = 1'b1;
            end

            APB_ACCESS: begin
                // pready is checked first so a completion on the limit cycle wins.
                if (apb.pready) begin
                    state_d     = APB_IDLE;
                    cmd_ready_d = 1'b1;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_d.rdata = pwrite_q ? '0 : APB_DATA_W'(apb.prdata);
                    rsp_d.err   = apb.pslverr;
                end else if (timer_expired) begin
                    state_d       = APB_IDLE;
                    cmd_ready_d   = 1'b1;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_d.err     = 1'b1;
                    rsp_d.timeout = 1'b1;
                end
            end

            default: begin
                state_d     = APB_IDLE;
                cmd_ready_d = 1'b0;
                psel_d      = 1'b0;
                penable_d   = 1'b0;
            end
        endcase
    end

    // Single FSM register bank; async reset drops any transfer in flight.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q     <= APB_IDLE;
            cmd_ready_q <= 1'b0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_q       <= '0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_q       <= rsp_d;
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign apb.psel    = psel_q;
    assign apb.penable = penable_q;
    assign apb.pwrite  = pwrite_q;
    assign apb.paddr   = paddr_q;
    assign apb.pwdata  = pwdata_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = DATA_W'(rsp_q.rdata);
    assign rsp_err     = rsp_q.err;
    assign rsp_timeout = rsp_q.timeout;

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: a behavioural APB completer with programmable wait states,
// stuck-low pready and pslverr, plus a transaction-level model of expected responses.
module tb_apb_master;

    localparam int TIMEOUT = 8;

    logic        pclk = 1'b0;
    logic        presetn = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;

    int vectors = 0;
    int miscompares = 0;

    apb_if #(.ADDR_W(32), .DATA_W(32)) apb ();

    apb_master #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .pclk        (pclk),
        .presetn     (presetn),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .apb         (apb)
    );

    always #5 pclk = ~pclk;

    // ---------------- behavioural completer ----------------
    logic [31:0] mem [256];
    logic [31:0] ref_mem [256];
    int          cfg_waits = 0;
    bit          cfg_stuck = 1'b0;
    bit          cfg_err = 1'b0;
    int          waits_left = 0;

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 32'(i);
            ref_mem[i] = 32'(i);
        end
    end

    // Completer drives its outputs mid-cycle; garbage on pslverr/prdata while not ready.
    always @(negedge pclk) begin
        if (apb.psel && apb.penable) begin
            if (cfg_stuck || waits_left > 0) begin
                apb.pready  <= 1'b0;
                apb.pslverr <= 1'($urandom);
                apb.prdata  <= $urandom;
                if (waits_left > 0) waits_left <= waits_left - 1;
            end else begin
                apb.pready  <= 1'b1;
                apb.pslverr <= cfg_err;
                apb.prdata  <= apb.pwrite ? $urandom : mem[apb.paddr[7:0]];
            end
        end else begin
            apb.pready  <= 1'b0;
            apb.pslverr <= 1'b0;
            apb.prdata  <= $urandom;
            waits_left  <= cfg_waits;
        end
    end

    always @(posedge pclk) begin
        if (apb.psel && apb.penable && apb.pready && apb.pwrite && !apb.pslverr)
            mem[apb.paddr[7:0]] <= apb.pwdata;
    end

    // ---------------- helpers ----------------
    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    // One complete transfer: model the outcome, then watch every cycle until the response.
    task automatic do_xfer(input string name, input logic wr, input logic [7:0] addr,
                           input logic [31:0] wdata, input int waits, input bit stuck,
                           input bit err);
        int          exp_lat;
        int          cyc;
        int          n;
        bit          got;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic        exp_to;

        cfg_waits = waits;
        cfg_stuck = stuck;
        cfg_err   = err;
        if (stuck || waits >= TIMEOUT) begin
            exp_lat   = 2 + TIMEOUT;
            exp_rdata = '0;
            exp_err   = 1'b1;
            exp_to    = 1'b1;
        end else begin
            exp_lat   = 3 + waits;
            exp_rdata = wr ? 32'h0 : ref_mem[addr];
            exp_err   = err;
            exp_to    = 1'b0;
            if (wr && !err) ref_mem[addr] = wdata;
        end

        n = 0;
        while (cmd_ready !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        vectors++;
        if (cmd_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL %s cmd_ready got %b want 1", name, cmd_ready);
            return;
        end

        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = 32'(addr);
        cmd_wdata = wdata;
        step();
        cmd_valid = 1'b0;
        cmd_addr  = $urandom;
        cmd_wdata = $urandom;
        cmd_write = 1'($urandom);

        cyc = 1;
        got = 1'b0;
        while (!got && cyc <= exp_lat + 4) begin
            vectors++;
            if (rsp_valid === 1'b1) begin
                got = 1'b1;
                if (cyc != exp_lat || {rsp_rdata, rsp_err, rsp_timeout} !== {exp_rdata, exp_err, exp_to}) begin
                    miscompares++;
                    $display("FAIL %s rsp cycle=%0d rdata=%h err=%b to=%b want cycle=%0d rdata=%h err=%b to=%b",
                             name, cyc, rsp_rdata, rsp_err, rsp_timeout, exp_lat, exp_rdata, exp_err, exp_to);
                end
                vectors++;
                if ({apb.psel, apb.penable, cmd_ready} !== 3'b001) begin
                    miscompares++;
                    $display("FAIL %s rsp-cycle psel/penable/cmd_ready got %b%b%b want 001",
                             name, apb.psel, apb.penable, cmd_ready);
                end
            end else begin
                if ({apb.psel, apb.penable, apb.pwrite, apb.paddr} !== {1'b1, (cyc >= 2), wr, 32'(addr)}
                    || (wr && apb.pwdata !== wdata) || cmd_ready !== 1'b0) begin
                    miscompares++;
                    $display("FAIL %s bus cycle=%0d psel=%b penable=%b pwrite=%b paddr=%h pwdata=%h rdy=%b want 1 %b %b %h %h 0",
                             name, cyc, apb.psel, apb.penable, apb.pwrite, apb.paddr, apb.pwdata,
                             cmd_ready, (cyc >= 2), wr, 32'(addr), wdata);
                end
                step();
                cyc++;
            end
        end
        if (!got) begin
            vectors++;
            miscompares++;
            $display("FAIL %s rsp_valid never seen, want cycle %0d", name, exp_lat);
            return;
        end

        step();
        vectors++;
        if ({rsp_valid, rsp_rdata, rsp_err, rsp_timeout} !== '0) begin
            miscompares++;
            $display("FAIL %s rsp clear got v=%b rdata=%h err=%b to=%b want all 0",
                     name, rsp_valid, rsp_rdata, rsp_err, rsp_timeout);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        presetn = 1'b0;
        repeat (2) @(posedge pclk);
        #1;
        vectors++;
        if ({apb.psel, apb.penable, apb.pwrite, apb.paddr, apb.pwdata,
             rsp_valid, rsp_rdata, rsp_err, rsp_timeout, cmd_ready} !== '0) begin
            miscompares++;
            $display("FAIL reset_state psel=%b pen=%b pwr=%b paddr=%h pwdata=%h rv=%b rd=%h err=%b to=%b rdy=%b want all 0",
                     apb.psel, apb.penable, apb.pwrite, apb.paddr, apb.pwdata,
                     rsp_valid, rsp_rdata, rsp_err, rsp_timeout, cmd_ready);
        end
        presetn = 1'b1;
        #1;
        vectors++;
        if (cmd_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release_ready got %b want 0 before first edge", cmd_ready);
        end
        step();
        vectors++;
        if (cmd_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_first_edge_ready got %b want 1", cmd_ready);
        end
    endtask

    task automatic test_basic();
        do_xfer("rd5_after_reset", 1'b0, 8'd5, 32'h0, 0, 1'b0, 1'b0);
        do_xfer("wr5_deadbeef", 1'b1, 8'd5, 32'hDEADBEEF, 0, 1'b0, 1'b0);
        vectors++;
        if (mem[5] !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL slave_mem5 got %h want deadbeef", mem[5]);
        end
        do_xfer("wr7_a5", 1'b1, 8'd7, 32'h000000A5, 0, 1'b0, 1'b0);
        do_xfer("rd7_a5", 1'b0, 8'd7, 32'h0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_wait_states();
        do_xfer("rd_wait3", 1'b0, 8'd5, 32'h0, 3, 1'b0, 1'b0);
        do_xfer("wr_wait2", 1'b1, 8'd20, $urandom, 2, 1'b0, 1'b0);
        do_xfer("rd_wait_limit_minus1", 1'b0, 8'd20, 32'h0, TIMEOUT - 1, 1'b0, 1'b0);
    endtask

    task automatic test_timeout();
        do_xfer("rd_stuck_timeout", 1'b0, 8'd30, 32'h0, 0, 1'b1, 1'b0);
        do_xfer("wr_wait_eq_limit", 1'b1, 8'd31, $urandom, TIMEOUT, 1'b0, 1'b0);
        do_xfer("rd_after_timeout", 1'b0, 8'd31, 32'h0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_slverr();
        do_xfer("wr_slverr", 1'b1, 8'd9, $urandom, 0, 1'b0, 1'b1);
        do_xfer("rd_slverr_wait", 1'b0, 8'd9, 32'h0, 2, 1'b0, 1'b1);
        do_xfer("rd_after_slverr", 1'b0, 8'd9, 32'h0, 1, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [7:0] addrs [4];
        int         acc_cyc [4];
        int         n_acc;
        int         n_rsp;
        int         cyc;
        bit         accepting;

        cfg_waits = 0;
        cfg_stuck = 1'b0;
        cfg_err   = 1'b0;
        for (int i = 0; i < 4; i++) addrs[i] = 8'($urandom_range(16, 255));
        n_acc = 0;
        n_rsp = 0;
        cyc   = 0;
        cmd_write = 1'b0;
        cmd_addr  = 32'(addrs[0]);
        cmd_valid = 1'b1;
        while (n_rsp < 4 && cyc < 40) begin
            accepting = cmd_valid && cmd_ready;
            step();
            cyc++;
            if (accepting) begin
                acc_cyc[n_acc] = cyc;
                n_acc++;
                if (n_acc < 4) cmd_addr = 32'(addrs[n_acc]);
                else cmd_valid = 1'b0;
            end
            if (rsp_valid === 1'b1) begin
                vectors++;
                if ({rsp_rdata, rsp_err} !== {ref_mem[addrs[n_rsp]], 1'b0}) begin
                    miscompares++;
                    $display("FAIL b2b_rsp%0d rdata=%h err=%b want %h 0",
                             n_rsp, rsp_rdata, rsp_err, ref_mem[addrs[n_rsp]]);
                end
                n_rsp++;
            end
        end
        cmd_valid = 1'b0;
        vectors++;
        if (n_rsp != 4 || n_acc != 4) begin
            miscompares++;
            $display("FAIL b2b_count accepts=%0d rsps=%0d want 4 4", n_acc, n_rsp);
        end else begin
            for (int i = 1; i < 4; i++) begin
                vectors++;
                if (acc_cyc[i] - acc_cyc[i-1] != 3) begin
                    miscompares++;
                    $display("FAIL b2b_spacing%0d got %0d cycles want 3", i, acc_cyc[i] - acc_cyc[i-1]);
                end
            end
        end
        step();
    endtask

    task automatic test_random();
        int waits;
        for (int i = 0; i < 24; i++) begin
            waits = ($urandom_range(0, 5) == 0) ? $urandom_range(TIMEOUT - 1, TIMEOUT + 1)
                                                : $urandom_range(0, 3);
            do_xfer("random", 1'($urandom), 8'($urandom_range(16, 255)), $urandom,
                    waits, 1'b0, ($urandom_range(0, 7) == 0));
        end
    endtask

    task automatic test_reset_mid_transfer();
        bit saw_rsp;

        cfg_stuck = 1'b1;
        cfg_waits = 0;
        cfg_err   = 1'b0;
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 32'd9;
        step();
        cmd_valid = 1'b0;
        step();
        step();
        vectors++;
        if ({apb.psel, apb.penable} !== 2'b11) begin
            miscompares++;
            $display("FAIL mid_reset_in_access psel/penable got %b%b want 11", apb.psel, apb.penable);
        end
        #3;
        presetn = 1'b0;
        #1;
        vectors++;
        if ({apb.psel, apb.penable, cmd_ready} !== 3'b000) begin
            miscompares++;
            $display("FAIL mid_reset_async psel/penable/cmd_ready got %b%b%b want 000",
                     apb.psel, apb.penable, cmd_ready);
        end
        saw_rsp = 1'b0;
        repeat (2) begin
            step();
            if (rsp_valid !== 1'b0) saw_rsp = 1'b1;
        end
        presetn = 1'b1;
        cfg_stuck = 1'b0;
        repeat (5) begin
            step();
            if (rsp_valid !== 1'b0) saw_rsp = 1'b1;
        end
        vectors++;
        if (saw_rsp) begin
            miscompares++;
            $display("FAIL mid_reset_no_rsp got rsp_valid=1 want 0 for dropped transfer");
        end
        do_xfer("rd3_after_mid_reset", 1'b0, 8'd3, 32'h0, 0, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wait_states();
        test_timeout();
        test_slverr();
        test_back_to_back();
        test_random();
        test_reset_mid_transfer();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Hard stop in case any stimulus path stalls.
    initial begin
        #200000;
        $display("FAIL global_time_limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1);
    end

endmodule
